// File: rtl/uart_rx.sv
// Purpose: 8N1-style UART receiver with its own per-bit timer; flags stop-bit errors.
// Latency: data_valid about (DATA_BITS+1)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles after the start edge.
// Backpressure: none; data_valid and frame_err are single-cycle pulses with no ready.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        clk_cnt, clk_cnt_nxt;
  logic [IW-1:0]        bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_out_nxt;
  logic                 data_valid_nxt;
  logic                 frame_err_nxt;
  logic                 rx_meta, rx_s;

  // Two-flop synchroniser; reset to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt      = state;
    clk_cnt_nxt    = clk_cnt;
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nxt = '0;
          // Line back high at mid start bit means a glitch, not a frame.
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt        = '0;
          shreg_nxt[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + IW'(1);
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            data_out_nxt   = shreg;
            data_valid_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BRK;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      BRK: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
      end
    endcase
  end

endmodule
